// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MEM-stage data memory responder.
//   dmem_state_t  : responder FSM state encoding (IDLE / WAIT / RESP)
//   DMEM_DEPTH    : default number of 32-bit words in the data memory
//   DMEM_LATENCY  : default wait cycles between acceptance and response
//   DMEM_CNT_W    : width of the latency counter (LATENCY range 0..15)
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int DMEM_DEPTH   = 32;
  localparam int DMEM_LATENCY = 2;
  localparam int DMEM_CNT_W   = 4;
  localparam int DMEM_WORD_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Address bits needed to index a memory of the given depth; never below 1
  // so a single-word memory still gets a legal index port.
  function automatic int dmem_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : mips_pkg

// File: rtl/data_mem_resp_if.sv
// -----------------------------------------------------------------------------
// data_mem_resp_if
// Request/response bundle between the MEM stage (master) and the data memory
// responder (slave).
//   req_valid  : access request present            (master -> slave)
//   req_we     : 1 = store, 0 = load                (master -> slave)
//   req_addr   : word address                       (master -> slave)
//   req_wdata  : store data                         (master -> slave)
//   req_ready  : responder can accept this cycle    (slave -> master)
//   resp_valid : one-cycle response strobe         (slave -> master)
//   resp_rdata : load data, 0 for stores and errors (slave -> master)
//   resp_err   : address out of range               (slave -> master)
//   stall      : pipeline hold request              (slave -> master)
// -----------------------------------------------------------------------------
interface data_mem_resp_if;
  import mips_pkg::*;

  logic                   req_valid;
  logic                   req_we;
  logic [DMEM_WORD_W-1:0] req_addr;
  logic [DMEM_WORD_W-1:0] req_wdata;
  logic                   req_ready;
  logic                   resp_valid;
  logic [DMEM_WORD_W-1:0] resp_rdata;
  logic                   resp_err;
  logic                   stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );

endinterface : data_mem_resp_if

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word-addressed storage for the data memory responder.
//   clk       : clock, all updates on the rising edge
//   rst_n     : synchronous active-low reset; loads mem[i] = i
//   wr_en_i   : write wdata_i to addr_i on this edge
//   rd_en_i   : sample mem[addr_i] into the read register on this edge
//   addr_i    : word index (caller guarantees addr_i < DEPTH)
//   wdata_i   : write data
//   rdata_o   : registered read data, held until the next read
// -----------------------------------------------------------------------------
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = dmem_addr_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic                   rd_en_i,
  input  logic [AW-1:0]          addr_i,
  input  logic [DMEM_WORD_W-1:0] wdata_i,
  output logic [DMEM_WORD_W-1:0] rdata_o
);

  logic [DMEM_WORD_W-1:0] mem_q [DEPTH];
  logic [DMEM_WORD_W-1:0] rdata_q;

  // NOTE: the storage is reset on purpose: the memory must come out of reset
  // holding mem[i] = i, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DMEM_WORD_W'(i);
      end
    end else if (wr_en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read data is captured once at acceptance and then held, so the response
  // can be presented any number of wait cycles later.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : dmem_array

// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
// MEM-stage data memory responder. Accepts one load/store at a time, waits
// LATENCY cycles, then returns a one-cycle response.
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : data_mem_resp_if.slave (request in, response/stall out)
// Parameters:
//   DEPTH   : number of 32-bit words
//   LATENCY : wait cycles between acceptance and response (0..15)
// Timing: a request accepted on edge k is answered in the (LATENCY+1)th cycle
// after that edge; the FSM is back in IDLE the cycle after, so back-to-back
// accesses run at one per LATENCY+2 cycles.
// -----------------------------------------------------------------------------
module data_mem_resp
  import mips_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_resp_if.slave bus
);

  localparam int AW = dmem_addr_w(DEPTH);

  dmem_state_t           state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q,   cnt_d;
  logic                  is_load_q, is_load_d;
  logic                  err_q,   err_d;

  logic                   accept;
  logic                   addr_oob;
  logic                   mem_wr_en;
  logic                   mem_rd_en;
  logic [DMEM_WORD_W-1:0] mem_rdata;

  // Requests are only looked at in IDLE; anything on the bus during WAIT or
  // RESP is ignored, so dropping req_valid mid-transaction is harmless.
  assign accept   = bus.req_valid && (state_q == IDLE);
  assign addr_oob = (bus.req_addr >= DMEM_WORD_W'(DEPTH));

  // Out-of-range accesses never touch the array; the error is reported in RESP.
  assign mem_wr_en = accept && !addr_oob &&  bus.req_we;
  assign mem_rd_en = accept && !addr_oob && !bus.req_we;

  // NOTE: every always_comb output gets a default first (hold current value)
  // so no path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_load_d = is_load_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          is_load_d = !bus.req_we;
          err_d     = addr_oob;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = DMEM_CNT_W'(LATENCY);
          end
        end
      end

      // The counter spends exactly LATENCY cycles here: the edge that takes it
      // from 1 to 0 is also the edge that enters RESP.
      WAIT: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        if (cnt_q <= DMEM_CNT_W'(1)) begin
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset aborts any in-flight transaction: the FSM drops back to IDLE and no
  // response is produced for it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_load_q <= is_load_d;
      err_q     <= err_d;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dmem_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en_i (mem_wr_en),
    .rd_en_i (mem_rd_en),
    .addr_i  (bus.req_addr[AW-1:0]),
    .wdata_i (bus.req_wdata),
    .rdata_o (mem_rdata)
  );

  // All outputs decode registered state, so they are glitch-free and hold
  // steady between events. Read data is forced to 0 outside RESP, for stores
  // and for out-of-range accesses.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = ((state_q == RESP) && is_load_q && !err_q) ? mem_rdata : '0;

  // The MEM stage holds while a request is waiting for acceptance or a
  // transaction is in flight; the RESP cycle releases it.
  assign bus.stall = (bus.req_valid && (state_q != RESP)) || (state_q == WAIT);

endmodule : data_mem_resp

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameters SHALL be, one per line:
  DEPTH    32   number of 32-bit words
  LATENCY  2    wait cycles inserted between acceptance and response (0..15)
REQ-002 Ports SHALL be, one per line:
  clk         in   1   single clock; all state updates on its rising edge
  rst_n       in   1   synchronous, active-low reset
  req_valid   in   1   MEM-stage access request present
  req_we      in   1   1 = store, 0 = load
  req_addr    in   32  word address
  req_wdata   in   32  store data
  req_ready   out  1   responder can accept a request this cycle
  resp_valid  out  1   one-cycle response strobe
  resp_rdata  out  32  load data; 0 for stores and errors
  resp_err    out  1   address out of range
  stall       out  1   pipeline hold request to the MEM stage
REQ-003 Clock and reset SHALL be exactly as stated: one clock clk; reset rst_n synchronous, active-low.

Function
REQ-004 The block SHALL be an FSM with states IDLE, WAIT, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid && req_ready.
REQ-006 On acceptance the FSM SHALL go to WAIT with counter = LATENCY, or directly to RESP if LATENCY == 0.
REQ-007 In WAIT the counter SHALL decrement each cycle; when it reaches 0 the FSM SHALL enter RESP on the following edge.
REQ-008 resp_valid SHALL be 1 for exactly one cycle (RESP); the FSM SHALL then return to IDLE. resp_valid is high LATENCY+1 cycles after the acceptance edge.
REQ-009 Stores SHALL commit memory[req_addr] = req_wdata on the acceptance edge; loads SHALL latch memory[req_addr] on the acceptance edge.
REQ-010 resp_rdata SHALL carry the latched load data in RESP, and 0 in all other cycles and for stores.
REQ-011 If req_addr >= DEPTH: no write SHALL occur, resp_rdata = 0, and resp_err = 1 in RESP; otherwise resp_err = 0.
REQ-012 Request inputs SHALL be ignored outside IDLE; deasserting req_valid during WAIT SHALL NOT cancel the transaction.
REQ-013 stall SHALL be combinational: (req_valid && state != RESP) || state == WAIT.
REQ-014 The initiator holds the request until resp_valid. A request presented in the cycle after RESP SHALL be accepted normally, giving a throughput of one access per LATENCY+2 cycles.
REQ-015 Output registers SHALL hold their values when no event occurs; no X SHALL propagate to any output after reset.

Reset
REQ-016 When rst_n = 0 at a rising edge: state = IDLE, counter = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-017 Reset SHALL initialise memory[i] = i for all i < DEPTH.
REQ-018 Reset mid-transaction SHALL abort the transaction with no response. A store already committed at acceptance remains overwritten by the reset initialisation.
REQ-019 req_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-020 A shared package mips_pkg SHALL hold the dmem_state_t enum (IDLE/WAIT/RESP) and the DMEM_DEPTH and DMEM_LATENCY default constants.
REQ-021 One sub-module, dmem_array, SHALL hold the storage: synchronous write, read sampled on enable, and reset initialisation. The FSM and counter SHALL stay in data_mem_resp.

Verification
REQ-022 Reset then load addr 5, LATENCY=2 -> req_ready=0 the cycle after acceptance; resp_valid 3 cycles after acceptance with rdata=5, err=0.
REQ-023 Store 0xDEADBEEF to addr 7, then load addr 7 -> second response rdata=0xDEADBEEF; first response rdata=0.
REQ-024 Load addr 40 (DEPTH=32) -> resp_err=1, rdata=0; a subsequent store to addr 40 leaves memory[0..31] unchanged.
REQ-025 LATENCY=0, back-to-back loads of addr 1 then 2 -> resp_valid in cycles k+1 and k+3 with rdata 1 and 2; stall low only in RESP cycles.
REQ-026 Assert rst_n=0 during WAIT of a store of 0x55 to addr 3 -> no resp_valid, and a later load of addr 3 returns 3.
REQ-027 Drop req_valid during WAIT -> the response still arrives on schedule and stall follows REQ-013.
